// File: rtl/stutter_pkg.sv
// Shared constants and types for the stutter free-running carry counter.
package stutter_pkg;
  localparam int              DEF_WIDTH    = 16;
  localparam longint unsigned DEF_TERMINAL = (64'd1 << DEF_WIDTH) - 64'd1;
  typedef logic [DEF_WIDTH-1:0] count_t;
endpackage

// File: rtl/stutter_counter.sv
// Count register with wrap-at-terminal next-state logic and a terminal flag.
module stutter_counter
  import stutter_pkg::*;
#(
  parameter int              WIDTH    = DEF_WIDTH,
  parameter longint unsigned TERMINAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] ps,
  output logic             term
);
  // Elaboration-time range checks on the parameters.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("stutter_counter: WIDTH %0d outside 2..32", WIDTH);
  end
  if (TERMINAL >= (64'd1 << WIDTH)) begin : g_bad_term
    $error("stutter_counter: TERMINAL %0d does not fit in WIDTH %0d", TERMINAL, WIDTH);
  end

  localparam logic [WIDTH-1:0] TERM = TERMINAL[WIDTH-1:0];

  logic [WIDTH-1:0] ns;

  assign term = (ps == TERM);

  // Plain modulo-2^WIDTH increment; values above TERM wrap naturally through 0.
  always_comb begin
    ns = ps + WIDTH'(1);
    if (term) ns = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ps <= '0;
    else       ps <= ns;
  end
endmodule

// File: rtl/stutter.sv
// Free-running stutter: one-cycle cy pulse every TERMINAL+1 clocks.
module stutter
  import stutter_pkg::*;
#(
  parameter int              WIDTH    = DEF_WIDTH,
  parameter longint unsigned TERMINAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic clk,
  input  logic reset,
  output logic cy
);
  logic [WIDTH-1:0] ps;
  logic             term;

  stutter_counter #(.WIDTH(WIDTH), .TERMINAL(TERMINAL)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .ps    (ps),
    .term  (term)
  );

  assign cy = term;
endmodule

// File: tb/tb_stutter.sv
// Randomized reset stimulus on three stutter configurations checked against an edge-count model.
module tb_stutter;
  import stutter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cy16, cy4, cy9;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;  // rising edges seen since reset was last released

  always #5 clk = ~clk;

  stutter                               d16 (.clk(clk), .reset(reset), .cy(cy16));
  stutter #(.WIDTH(4))                  d4  (.clk(clk), .reset(reset), .cy(cy4));
  stutter #(.WIDTH(4), .TERMINAL(9))    d9  (.clk(clk), .reset(reset), .cy(cy9));

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count value is simply edges-since-release modulo the period.
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  always @(negedge clk) begin
    int e16, e4, e9;
    e16 = n % 65536;
    e4  = n % 16;
    e9  = n % 10;
    chk("ps16", longint'(d16.ps), e16);
    chk("cy16", cy16, (e16 == 65535) ? 1 : 0);
    chk("ps4",  longint'(d4.ps), e4);
    chk("cy4",  cy4, (e4 == 15) ? 1 : 0);
    chk("ps9",  longint'(d9.ps), e9);
    chk("cy9",  cy9, (e9 == 9) ? 1 : 0);
  end

  initial begin
    int run, hold, off, off2;
    count_t snap;

    // Reset held across 10 rising edges.
    #1 reset = 1'b1;
    #1;
    chk("async_reset_ps16", longint'(d16.ps), 0);
    repeat (10) @(posedge clk);
    #2;
    chk("hold_ps4", longint'(d4.ps), 0);
    chk("hold_cy4", cy4, 0);
    reset = 1'b0;

    // First terminal of the WIDTH=4/TERMINAL=9 instance after 9 edges.
    repeat (9) @(posedge clk);
    #2;
    chk("t9_cy_at_9", cy9, 1);
    chk("t9_ps_at_9", longint'(d9.ps), 9);
    @(posedge clk); #2;
    chk("t9_wrap_ps", longint'(d9.ps), 0);
    chk("t9_wrap_cy", cy9, 0);

    // 200 free-running cycles at default width.
    repeat (190) @(posedge clk);
    #2;
    snap = d16.ps;
    chk("ps16_after_200", longint'(snap), 200);
    chk("cy16_after_200", cy16, 0);

    // Drive d4 to 15, then reset mid-cycle without an edge.
    repeat (7) @(posedge clk);
    #2;
    chk("w4_ps_15", longint'(d4.ps), 15);
    chk("w4_cy_15", cy4, 1);
    #1 reset = 1'b1;
    #1;
    chk("w4_async_ps", longint'(d4.ps), 0);
    chk("w4_async_cy", cy4, 0);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2;
    chk("w4_first_edge_ps", longint'(d4.ps), 1);

    // Randomized run lengths and reset pulses at varying in-cycle offsets.
    for (int i = 0; i < 40; i++) begin
      run  = $urandom_range(1, 60);
      hold = $urandom_range(0, 3);
      off  = $urandom_range(1, 8); if (off >= 5) off++;   // avoid both clock edges
      off2 = $urandom_range(1, 8); if (off2 >= 5) off2++;
      repeat (run) @(posedge clk);
      #(off) reset = 1'b1;
      repeat (hold) @(posedge clk);
      if (hold == 0) @(posedge clk);
      #(off2) reset = 1'b0;
    end

    // Full default period: first pulse after 65535 edges, wrap on the next.
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    repeat (65534) @(posedge clk);
    #2;
    chk("d16_pre_term_cy", cy16, 0);
    @(posedge clk); #2;
    chk("d16_term_cy", cy16, 1);
    chk("d16_term_ps", longint'(d16.ps), 65535);
    @(posedge clk); #2;
    chk("d16_wrap_ps", longint'(d16.ps), 0);
    chk("d16_wrap_cy", cy16, 0);
    repeat (50) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stutter.md
STUTTER -- requirements
Module: stutter

Interface
REQ-001 Parameter WIDTH, default 16: counter width in bits, legal range 2..32.
REQ-002 Parameter TERMINAL, default all-ones (2^WIDTH-1): count value at which cy asserts and the counter wraps.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset; clears all state immediately.
REQ-005 Port cy, output, 1 bit: carry/stutter pulse, high for exactly one clock cycle per counter period.

Function
REQ-006 The block SHALL hold an internal WIDTH-bit unsigned count register (ps).
REQ-007 cy SHALL be combinational: cy = 1 iff ps == TERMINAL, else 0; no extra register stage.
REQ-008 On each rising clk edge with reset low, ps SHALL load the next value (ns): 0 if ps == TERMINAL, else ps + 1.
REQ-009 The increment SHALL be modulo 2^WIDTH; no carry beyond WIDTH bits is kept.
REQ-010 The period SHALL be TERMINAL+1 cycles: 65536 at default; cy high 1 cycle, low 65535.
REQ-011 After reset release, the first cy assertion SHALL occur while ps == TERMINAL, i.e. after TERMINAL rising edges (65535 at default).
REQ-012 The wrap from TERMINAL to 0 SHALL occur on the same edge that ends the cy pulse; cy is low in the following cycle.
REQ-013 If TERMINAL < 2^WIDTH-1, values above TERMINAL SHALL be unreachable from reset; if reached, the counter counts up and wraps naturally through 0.
REQ-014 The block SHALL have no enable, load or external count inputs; counting is free-running whenever reset is low.

Reset
REQ-015 While reset is high, ps SHALL be 0 regardless of clk, and therefore cy SHALL be 0.
REQ-016 Reset assertion SHALL take effect without a clock edge; if ps == TERMINAL, cy drops in the same timestep.
REQ-017 Reset mid-count SHALL discard progress; counting restarts from 0 on the first rising edge after deassertion, with ps becoming 1 on that edge.
REQ-018 Reset deassertion coincident with a rising edge SHALL leave ps at 0 for that edge; counting begins on the next edge.

Structure
REQ-019 The default WIDTH and the derived all-ones TERMINAL constant SHALL live in a shared package (stutter_pkg), together with a count_t typedef of WIDTH bits.
REQ-020 The register-plus-next-state logic SHALL be one sub-module, stutter_counter, with outputs ps and a terminal flag; stutter instantiates it and drives cy from the flag.
REQ-021 Next-state and cy logic SHALL be purely combinational; the only sequential element is the ps register, with asynchronous reset.
REQ-022 A parameter check SHALL flag WIDTH outside 2..32 or TERMINAL >= 2^WIDTH at elaboration.

Verification
REQ-023 Reset high for one cycle, then 200 free-running cycles at default parameters -> cy stays 0 throughout; ps reads 200 at the end.
REQ-024 Default parameters, 65535 edges after reset release -> cy = 1 for exactly that cycle; the next edge gives ps = 0 and cy = 0; the next pulse comes 65536 cycles later.
REQ-025 WIDTH=4 -> cy high at cycles 15, 31, 47, ...; low on every other cycle over 64 cycles.
REQ-026 WIDTH=4, TERMINAL=9 -> cy high when ps = 9 at cycles 9, 19, 29; ps sequence is 0..9 repeating.
REQ-027 WIDTH=4 with ps = 15 and cy = 1, reset asserted mid-cycle with no clock edge -> ps = 0 and cy = 0 immediately; after release, ps = 1 after the first edge.
REQ-028 Reset held high across 10 rising edges -> ps stays 0 and cy stays 0 for all 10 edges.
